branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 110 +++++++++++
 tb/tb_branch_predictor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Branch predictor: 16-entry direct-mapped table of 2-bit saturating
// counters with branch targets. Combinational lookup on fetch_pc, update on
// resolution of beq/bne. Also keeps saturating branch/mispredict counters.
module branch_predictor (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        predict_hit,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic [5:0]  update_opcode,
  input  logic        update_taken,
  input  logic        update_pred_taken,
  input  logic [31:0] update_target,
  output logic        mispredict,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
);

  localparam logic [5:0]  OPC_BEQ  = 6'b000100;
  localparam logic [5:0]  OPC_BNE  = 6'b000101;
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;
  localparam int          ENTRIES  = 16;

  // Table storage: valid/ctr are reset, tag/target are not.
  logic        valid_q  [ENTRIES];
  logic [1:0]  ctr_q    [ENTRIES];
  logic [5:0]  tag_q    [ENTRIES];
  logic [31:0] target_q [ENTRIES];

  logic [3:0]  fetch_idx;
  logic [3:0]  upd_idx;
  logic        upd_qual;
  logic        upd_hit;
  logic        upd_mispredict;
  logic [1:0]  upd_ctr;
  logic        upd_write_target;

  // Only the index/tag bits of update_pc select an entry.
  logic unused_update_pc_bits;
  assign unused_update_pc_bits = ^{update_pc[31:12], update_pc[1:0]};

  // Combinational lookup; reads pre-update table contents.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    predict_hit    = 1'b0;
    predict_taken  = 1'b0;
    predict_target = fetch_pc + 32'd4;
    fetch_idx      = fetch_pc[5:2];
    predict_hit    = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_pc[11:6]);
    predict_taken  = predict_hit && ctr_q[fetch_idx][1];
    if (predict_taken) begin
      predict_target = target_q[fetch_idx];
    end
  end

  // Update decode: qualification, hit detection and next counter value.
  always_comb begin
    upd_idx          = update_pc[5:2];
    upd_qual         = update_valid &&
                       ((update_opcode == OPC_BEQ) || (update_opcode == OPC_BNE));
    upd_hit          = valid_q[upd_idx] && (tag_q[upd_idx] == update_pc[11:6]);
    upd_mispredict   = upd_qual && (update_taken != update_pred_taken);
    upd_write_target = upd_qual && (!upd_hit || update_taken);
    upd_ctr          = ctr_q[upd_idx];
    if (!upd_hit) begin
      upd_ctr = update_taken ? 2'b10 : 2'b01;
    end else if (update_taken) begin
      if (ctr_q[upd_idx] != 2'b11) upd_ctr = ctr_q[upd_idx] + 2'd1;
    end else begin
      if (ctr_q[upd_idx] != 2'b00) upd_ctr = ctr_q[upd_idx] - 2'd1;
    end
  end

  // Valid bits, counters and statistics; reset wins over any update.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b00;
      end
      mispredict       <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      mispredict <= upd_mispredict;
      if (upd_qual) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= upd_ctr;
        if (branch_count != CNT_MAX) branch_count <= branch_count + 16'd1;
      end
      if (upd_mispredict && (mispredict_count != CNT_MAX)) begin
        mispredict_count <= mispredict_count + 16'd1;
      end
    end
  end

  // Tag and target payload; only written on non-reset qualified updates.
  always_ff @(posedge clk) begin
    // NOTE: tag/target are deliberately not reset; valid=0 masks them, letting them map to plain RAM.
    if (!rst && upd_qual) begin
      if (!upd_hit) tag_q[upd_idx] <= update_pc[11:6];
      if (upd_write_target) target_q[upd_idx] <= update_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: table of directed per-cycle
// vectors plus hand-written reset and counter-saturation sequences.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        predict_hit;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [5:0]  update_opcode;
  logic        update_taken;
  logic        update_pred_taken;
  logic [31:0] update_target;
  logic        mispredict;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;
  localparam logic [5:0] LW  = 6'b100011;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk               (clk),
    .rst               (rst),
    .fetch_pc          (fetch_pc),
    .predict_hit       (predict_hit),
    .predict_taken     (predict_taken),
    .predict_target    (predict_target),
    .update_valid      (update_valid),
    .update_pc         (update_pc),
    .update_opcode     (update_opcode),
    .update_taken      (update_taken),
    .update_pred_taken (update_pred_taken),
    .update_target     (update_target),
    .mispredict        (mispredict),
    .branch_count      (branch_count),
    .mispredict_count  (mispredict_count)
  );

  typedef struct {
    logic [31:0] fpc;
    logic        uv;
    logic [5:0]  op;
    logic [31:0] upc;
    logic        ut;
    logic        upt;
    logic [31:0] utgt;
    logic        e_hit;
    logic        e_tk;
    logic [31:0] e_tgt;
    logic        e_mp;
    logic [15:0] e_bc;
    logic [15:0] e_mc;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] fpc, input logic uv, input logic [5:0] op,
                              input logic [31:0] upc, input logic ut, input logic upt,
                              input logic [31:0] utgt, input logic e_hit, input logic e_tk,
                              input logic [31:0] e_tgt, input logic e_mp,
                              input logic [15:0] e_bc, input logic [15:0] e_mc);
    vec_t v;
    v.fpc = fpc; v.uv = uv; v.op = op; v.upc = upc; v.ut = ut; v.upt = upt; v.utgt = utgt;
    v.e_hit = e_hit; v.e_tk = e_tk; v.e_tgt = e_tgt; v.e_mp = e_mp; v.e_bc = e_bc; v.e_mc = e_mc;
    return v;
  endfunction

  task automatic drive(input logic [31:0] fpc, input logic uv, input logic [5:0] op,
                       input logic [31:0] upc, input logic ut, input logic upt,
                       input logic [31:0] utgt);
    fetch_pc = fpc; update_valid = uv; update_opcode = op; update_pc = upc;
    update_taken = ut; update_pred_taken = upt; update_target = utgt;
  endtask

  initial begin
    // Columns: fetch_pc, uv, op, upc, taken, pred, tgt | hit, tk, target (pre-edge) | mp, bc, mc (post-edge)
    // Cold miss then allocate at 0x40 (lookup in the update cycle sees old contents).
    vecs[0]  = mk(32'h40,  0, BEQ, 32'h0,   0, 0, 32'h0,   0, 0, 32'h44,  0, 0, 0);
    vecs[1]  = mk(32'h40,  1, BEQ, 32'h40,  1, 0, 32'h100, 0, 0, 32'h44,  1, 1, 1);
    vecs[2]  = mk(32'h40,  0, BEQ, 32'h0,   0, 0, 32'h0,   1, 1, 32'h100, 0, 1, 1);
    // Saturation/hysteresis at 0x80 (same index as 0x40, evicts it): ctr 1,2,3,3,2,1.
    vecs[3]  = mk(32'h80,  1, BNE, 32'h80,  0, 0, 32'h200, 0, 0, 32'h84,  0, 2, 1);
    vecs[4]  = mk(32'h80,  1, BEQ, 32'h80,  1, 0, 32'h200, 1, 0, 32'h84,  1, 3, 2);
    vecs[5]  = mk(32'h80,  1, BEQ, 32'h80,  1, 1, 32'h200, 1, 1, 32'h200, 0, 4, 2);
    vecs[6]  = mk(32'h80,  1, BEQ, 32'h80,  1, 1, 32'h200, 1, 1, 32'h200, 0, 5, 2);
    vecs[7]  = mk(32'h80,  1, BEQ, 32'h80,  0, 1, 32'h300, 1, 1, 32'h200, 1, 6, 3);
    vecs[8]  = mk(32'h80,  1, BNE, 32'h80,  0, 1, 32'h300, 1, 1, 32'h200, 1, 7, 4);
    vecs[9]  = mk(32'h80,  0, BEQ, 32'h0,   0, 0, 32'h0,   1, 0, 32'h84,  0, 7, 4);
    // Non-branch opcode and update_valid=0 leave everything unchanged.
    vecs[10] = mk(32'h80,  1, LW,  32'h80,  1, 0, 32'h400, 1, 0, 32'h84,  0, 7, 4);
    vecs[11] = mk(32'h80,  0, BEQ, 32'h80,  1, 0, 32'h500, 1, 0, 32'h84,  0, 7, 4);
    vecs[12] = mk(32'h80,  0, BEQ, 32'h0,   0, 0, 32'h0,   1, 0, 32'h84,  0, 7, 4);
    // Aliasing: 0x40 and 0x840 share index 0 with different tags.
    vecs[13] = mk(32'h40,  1, BEQ, 32'h40,  1, 1, 32'h100, 0, 0, 32'h44,  0, 8, 4);
    vecs[14] = mk(32'h840, 1, BEQ, 32'h840, 0, 1, 32'h900, 0, 0, 32'h844, 1, 9, 5);
    vecs[15] = mk(32'h40,  0, BEQ, 32'h0,   0, 0, 32'h0,   0, 0, 32'h44,  0, 9, 5);
    vecs[16] = mk(32'h840, 0, BEQ, 32'h0,   0, 0, 32'h0,   1, 0, 32'h844, 0, 9, 5);
    // Same-cycle collision: lookup sees ctr=1, next cycle sees ctr=2 and new target.
    vecs[17] = mk(32'h840, 1, BNE, 32'h840, 1, 0, 32'h980, 1, 0, 32'h844, 1, 10, 6);
    vecs[18] = mk(32'h840, 0, BEQ, 32'h0,   0, 0, 32'h0,   1, 1, 32'h980, 0, 10, 6);
    // Fall-through target wraps modulo 2^32.
    vecs[19] = mk(32'hFFFF_FFFC, 0, BEQ, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 10, 6);

    // Reset state.
    rst = 1'b1;
    drive(32'h40, 1'b0, BEQ, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset hit",    {31'd0, predict_hit},    32'd0);
    check("reset taken",  {31'd0, predict_taken},  32'd0);
    check("reset target", predict_target,          32'h44);
    check("reset mp",     {31'd0, mispredict},     32'd0);
    check("reset bc",     {16'd0, branch_count},   32'd0);
    check("reset mc",     {16'd0, mispredict_count}, 32'd0);
    fetch_pc = 32'h1234_5678;
    #1;
    check("reset target2", predict_target, 32'h1234_567C);
    @(negedge clk);
    rst = 1'b0;

    // Vector table.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].fpc, vecs[i].uv, vecs[i].op, vecs[i].upc, vecs[i].ut, vecs[i].upt, vecs[i].utgt);
      #1;
      check($sformatf("v%0d hit", i),    {31'd0, predict_hit},   {31'd0, vecs[i].e_hit});
      check($sformatf("v%0d taken", i),  {31'd0, predict_taken}, {31'd0, vecs[i].e_tk});
      check($sformatf("v%0d target", i), predict_target,         vecs[i].e_tgt);
      @(posedge clk);
      #1;
      check($sformatf("v%0d mp", i), {31'd0, mispredict},       {31'd0, vecs[i].e_mp});
      check($sformatf("v%0d bc", i), {16'd0, branch_count},     {16'd0, vecs[i].e_bc});
      check($sformatf("v%0d mc", i), {16'd0, mispredict_count}, {16'd0, vecs[i].e_mc});
    end

    // Drive both statistics counters past 16'hFFFF (bc starts at 10, mc at 6).
    @(negedge clk);
    drive(32'h44, 1'b1, BEQ, 32'h44, 1'b1, 1'b0, 32'h700);
    repeat (65535) @(posedge clk);
    #1;
    check("sat bc", {16'd0, branch_count},     32'h0000_FFFF);
    check("sat mc", {16'd0, mispredict_count}, 32'h0000_FFFF);
    check("sat mp", {31'd0, mispredict},       32'd1);

    // Reset together with a qualified mispredicting update: update discarded.
    @(negedge clk);
    rst = 1'b1;
    drive(32'h44, 1'b1, BNE, 32'h44, 1'b0, 1'b1, 32'h800);
    @(posedge clk);
    #1;
    check("rst mp",     {31'd0, mispredict},       32'd0);
    check("rst bc",     {16'd0, branch_count},     32'd0);
    check("rst mc",     {16'd0, mispredict_count}, 32'd0);
    check("rst hit",    {31'd0, predict_hit},      32'd0);
    check("rst target", predict_target,            32'h48);
    @(negedge clk);
    rst = 1'b0;
    drive(32'h840, 1'b0, BEQ, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    check("post-rst hit 0x840",    {31'd0, predict_hit},   32'd0);
    check("post-rst taken 0x840",  {31'd0, predict_taken}, 32'd0);
    check("post-rst target 0x840", predict_target,         32'h844);
    @(posedge clk);
    #1;
    check("post-rst mp", {31'd0, mispredict},   32'd0);
    check("post-rst bc", {16'd0, branch_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
